stereo_capture_sequencer: RTL
=============================

Name: stereo_capture_sequencer

Overview:
Sequences one stereo snapshot from the two camera pipelines (index 0 = right, index 1 = left) into their frame RAMs. It gates each capture path's RAM write enable so both buffers hold frames that started within a bounded skew. It freezes the buffers once both frames are complete, then grants exclusive read access to one downstream reader, either the display path or the distance engine. Sits between the camera-to-RAM writers and the RAM read side, clocked on sysclk.

Parameters:
SYNC_WIN, 4096, max sysclk cycles between the two frame starts (must be < 65535)
LINES, 240, expected href rising edges per captured frame
TIMEOUT, 4194304, max sysclk cycles spent in ARM/ALIGN/CAPTURE before abort

Ports:
sysclk  in  1  system clock, sole clock
rst_n  in  1  asynchronous active-low reset
vsync  in  2  raw camera vsync, high = vertical sync pulse, asynchronous to sysclk
href  in  2  raw camera href, high = active line, asynchronous to sysclk
start  in  1  one-cycle pulse: request a snapshot
continuous  in  1  level: rearm automatically after each read completes
clr_err  in  1  pulse: clear sticky error flags
capture_en  out  2  per-camera write-enable gate, ANDed with the writer's wren
frame_valid  out  1  both buffers hold a complete, aligned frame pair
rd_req  in  1  reader requests buffer access (level)
rd_gnt  out  1  reader owns both RAM read ports
rd_done  in  1  pulse: reader finished
busy  out  1  high in ARM, ALIGN, CAPTURE
skew  out  16  latched frame-start skew in sysclk cycles, saturating
line_cnt_r  out  9  lines captured on camera 0, saturating at 511
line_cnt_l  out  9  lines captured on camera 1, saturating at 511
err_skew  out  1  sticky: skew exceeded SYNC_WIN
err_lines  out  1  sticky: line count != LINES
err_timeout  out  1  sticky: TIMEOUT expired

Behaviour:
- Reset (async, rst_n low): state IDLE; every output 0, including counters, skew and error flags. Reset takes effect immediately mid-operation and drops capture_en the same instant.
- Input conditioning: vsync and href each pass through a 2-flop synchronizer plus one history flop. An edge is detected when sync stage 2 differs from the history flop.
- Frame start = vsync falling edge. Frame end = vsync rising edge. Line = href rising edge.
- capture_en changes on the sysclk edge after edge detection: nominally 3 cycles after the raw pin edge, 4 cycles worst case.
- IDLE: start pulse -> ARM. Clears the line counters and the timeout counter.
- ARM: both starts in the same cycle -> capture_en=11, skew=0 -> CAPTURE. One start only -> set that camera's capture_en, clear the skew counter -> ALIGN.
- ALIGN: skew counter increments each cycle. Other camera starts -> set its capture_en, latch skew -> CAPTURE. If the counter reaches SYNC_WIN first: err_skew=1, capture_en=00, clear line counters -> ARM.
- CAPTURE: each href rise on a camera with capture_en high increments that camera's line counter. Frame end on camera n clears capture_en[n] and marks camera n done.
- When both cameras are done and both counts equal LINES: -> HOLD with frame_valid=1.
- When both cameras are done and either count differs from LINES: err_lines=1 -> ARM.
- Timeout: the counter runs in ARM, ALIGN and CAPTURE. On reaching TIMEOUT: err_timeout=1, capture_en=00 -> IDLE.
- HOLD: frame_valid=1, capture_en=00.
  - rd_req high -> READ; rd_gnt rises the next cycle.
  - A start pulse without rd_req -> ARM and frame_valid clears.
  - If start and rd_req arrive in the same cycle, rd_req wins and start is discarded.
- READ: rd_gnt=1 and frame_valid=1; start is ignored.
  - On rd_done, rd_gnt is 0 the next cycle.
  - Then, with continuous=1: -> ARM and frame_valid clears. With continuous=0: -> HOLD and the frame stays valid.
- busy = state in {ARM, ALIGN, CAPTURE}.
- Error flags: set-dominant over clr_err in the same cycle. An error never changes rd_gnt.
- Line counters and skew saturate; they never wrap.
- Frame-end edges seen in ARM or ALIGN for a camera not yet enabled are ignored.

Test Plan:
1. Aligned capture: both vsync fall in the same cycle, 240 href pulses each, then vsync rises -> capture_en=11 within 4 cycles of the fall; skew=0; line_cnt_r=line_cnt_l=240; frame_valid=1; busy=0.
2. Skewed capture: camera 0 frame start 1000 cycles before camera 1 -> capture_en=01 then 11; skew=1000±1; frame_valid=1.
3. Excess skew: camera 1 starts 5000 cycles after camera 0 -> err_skew=1 and capture_en=00 after 4096 cycles, state ARM; the next aligned pair yields frame_valid=1; clr_err clears err_skew.
4. Line mismatch: camera 1 delivers 239 lines -> err_lines=1, frame_valid stays 0, busy=1 (re-armed).
5. Read handshake: in HOLD, assert rd_req together with start -> rd_gnt=1 next cycle, start ignored. rd_done with continuous=0 -> rd_gnt=0, frame_valid=1. Repeat with continuous=1 -> frame_valid=0, busy=1.
6. Timeout and reset: TIMEOUT=1000, start, no vsync -> err_timeout=1 at cycle 1000, state IDLE. rst_n low mid-CAPTURE -> all outputs 0 immediately.

Source files
------------

// File: rtl/stereo_capture_sequencer.sv
// stereo_capture_sequencer: aligns two camera frame starts, gates RAM writes, then hands the frozen pair to one reader
module stereo_capture_sequencer #(
    parameter int SYNC_WIN = 4096,
    parameter int LINES    = 240,
    parameter int TIMEOUT  = 4194304
) (
    input  logic        sysclk,
    input  logic        rst_n,
    input  logic [1:0]  vsync,
    input  logic [1:0]  href,
    input  logic        start,
    input  logic        continuous,
    input  logic        clr_err,
    output logic [1:0]  capture_en,
    output logic        frame_valid,
    input  logic        rd_req,
    output logic        rd_gnt,
    input  logic        rd_done,
    output logic        busy,
    output logic [15:0] skew,
    output logic [8:0]  line_cnt_r,
    output logic [8:0]  line_cnt_l,
    output logic        err_skew,
    output logic        err_lines,
    output logic        err_timeout
);
    localparam int TW = $clog2(TIMEOUT);
    typedef enum logic [2:0] {IDLE, ARM, ALIGN, CAPTURE, HOLD, READ} state_t;
    state_t state;
    logic [1:0] vs_s1, vs_s2, vs_h, hr_s1, hr_s2, hr_h, done;
    logic [1:0] vs_fall, vs_rise, hr_rise;
    logic [15:0] skew_cnt, skew_nxt;
    logic [TW-1:0] to_cnt;
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            {vs_s1, vs_s2, vs_h, hr_s1, hr_s2, hr_h} <= '0;
        end else begin
            vs_s1 <= vsync;
            vs_s2 <= vs_s1;
            vs_h  <= vs_s2;
            hr_s1 <= href;
            hr_s2 <= hr_s1;
            hr_h  <= hr_s2;
        end
    end
    assign vs_fall  = vs_h & ~vs_s2;
    assign vs_rise  = ~vs_h & vs_s2;
    assign hr_rise  = ~hr_h & hr_s2;
    assign skew_nxt = &skew_cnt ? skew_cnt : skew_cnt + 1'b1;
    assign busy     = state inside {ARM, ALIGN, CAPTURE};
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            capture_en  <= '0;
            frame_valid <= 1'b0;
            rd_gnt      <= 1'b0;
            skew        <= '0;
            skew_cnt    <= '0;
            line_cnt_r  <= '0;
            line_cnt_l  <= '0;
            done        <= '0;
            to_cnt      <= '0;
            err_skew    <= 1'b0;
            err_lines   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            if (clr_err)
                {err_skew, err_lines, err_timeout} <= '0;
            if (hr_rise[0] && capture_en[0] && line_cnt_r != 9'h1ff)
                line_cnt_r <= line_cnt_r + 1'b1;
            if (hr_rise[1] && capture_en[1] && line_cnt_l != 9'h1ff)
                line_cnt_l <= line_cnt_l + 1'b1;
            to_cnt <= busy ? to_cnt + 1'b1 : '0;
            if (busy && to_cnt == TW'(TIMEOUT - 1)) begin
                err_timeout <= 1'b1;
                capture_en  <= '0;
                done        <= '0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        line_cnt_r <= '0;
                        line_cnt_l <= '0;
                        state      <= ARM;
                    end
                    // Counters restart on every frame start so a failed attempt keeps its counts visible while re-armed
                    ARM: if (|vs_fall) begin
                        capture_en <= vs_fall;
                        line_cnt_r <= '0;
                        line_cnt_l <= '0;
                        done       <= '0;
                        skew_cnt   <= '0;
                        if (&vs_fall)
                            skew <= '0;
                        state <= &vs_fall ? CAPTURE : ALIGN;
                    end
                    ALIGN: if (|(vs_fall & ~capture_en)) begin
                        capture_en <= 2'b11;
                        skew       <= skew_nxt;
                        state      <= CAPTURE;
                    end else if (skew_nxt == 16'(SYNC_WIN)) begin
                        err_skew   <= 1'b1;
                        capture_en <= '0;
                        line_cnt_r <= '0;
                        line_cnt_l <= '0;
                        state      <= ARM;
                    end else begin
                        skew_cnt <= skew_nxt;
                    end
                    CAPTURE: if (&done) begin
                        if (line_cnt_r == 9'(LINES) && line_cnt_l == 9'(LINES)) begin
                            frame_valid <= 1'b1;
                            state       <= HOLD;
                        end else begin
                            err_lines <= 1'b1;
                            state     <= ARM;
                        end
                    end else begin
                        capture_en <= capture_en & ~vs_rise;
                        done       <= done | (vs_rise & capture_en);
                    end
                    HOLD: if (rd_req) begin
                        rd_gnt <= 1'b1;
                        state  <= READ;
                    end else if (start) begin
                        frame_valid <= 1'b0;
                        state       <= ARM;
                    end
                    READ: if (rd_done) begin
                        rd_gnt      <= 1'b0;
                        frame_valid <= ~continuous;
                        state       <= continuous ? ARM : HOLD;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
